serial_add_sequencer: RTL



---
 rtl/serial_add_sequencer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/serial_add_sequencer.sv
// ---------------------------------------------------------------------------
// serial_add_sequencer
//   Bit-serial add/subtract engine for the Hack datapath. One 1-bit full
//   adder (two half adders plus an OR) is walked across a WIDTH-bit word,
//   LSB first, one bit per clock.
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous, active-high reset
//   start     request a new operation (sampled on rising clk edge)
//   sub       0: a+b+cin   1: a-b (b inverted, initial carry 1, cin ignored)
//   cin       carry-in for add
//   a, b      operands, latched when start is accepted
//   busy      high while bits are being processed (state RUN)
//   done      one-cycle pulse when sum/cout/overflow become valid
//   sum       result, held stable outside RUN
//   cout      carry out of the MSB (for sub: 1 = no borrow)
//   overflow  two's-complement overflow (carry into MSB ^ carry out of MSB)
//   dbg_state current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Handshake: start is accepted only in IDLE or DONE; while busy=1 it is
// ignored and the operand registers are untouched. busy and done are
// decoded from the state register, so they are never high together and
// both drop immediately on reset.
// ---------------------------------------------------------------------------

module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_add_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic [1:0]       dbg_state
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last_bit;

  // Single full adder: (a0 ^ b0) ^ carry, carry-out = c0 | c1.
  logic ha0_s, ha0_c, fa_s, ha1_c, fa_c;

  half_adder u_ha0 (.x(a_sh[0]), .y(b_sh[0]), .s(ha0_s), .c(ha0_c));
  half_adder u_ha1 (.x(ha0_s),   .y(carry),   .s(fa_s),  .c(ha1_c));
  assign fa_c = ha0_c | ha1_c;

  assign last_bit = (cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and status decode
  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    dbg_state = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        state_d = start ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath. Operand load happens on the same edge that leaves IDLE/DONE
  // for RUN; the visible result registers are written only on the edge
  // that processes the MSB, so partial sums are never exposed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sh     <= '0;
      b_sh     <= '0;
      sum_sh   <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
          carry  <= fa_c;
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            // carry currently holds the carry into the MSB
            sum      <= {fa_s, sum_sh[WIDTH-1:1]};
            cout     <= fa_c;
            overflow <= carry ^ fa_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
